// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: instruction RAM fetch responder with a 2-entry response FIFO and a loader port.
// Define MISALIGN_CHECK_EN to return err=2 for fetches whose PC is not word aligned.
module imem_fetch_responder #(
   parameter int XLEN = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [XLEN-1:0]       req_pc,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [XLEN-1:0]       rsp_instr,
   output logic [XLEN-1:0]       rsp_pc,
   output logic [1:0]            rsp_err,
   input  logic                  flush,
   input  logic                  ld_we,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [XLEN-1:0]       ld_data
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [XLEN-1:0]       mem_q [DEPTH];
   logic [XLEN-1:0]       rdata_q;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic                  if_vld_q, if_vld_d;
   logic [XLEN-1:0]       if_pc_q, if_pc_d;
   logic [1:0]            if_err_q, if_err_d;
   logic [XLEN-1:0]       if_instr;
   logic [XLEN-1:0]       fifo_instr_q [2];
   logic [XLEN-1:0]       fifo_pc_q [2];
   logic [1:0]            fifo_err_q [2];
   logic                  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [1:0]            cnt_q, cnt_d, occ, req_err;
   logic                  accept, oor, mis, fifo_head, pop_ff, pop_if, push;

   assign rd_idx = req_pc[DEPTH_LOG2+1:2];
   assign oor = |req_pc[XLEN-1:DEPTH_LOG2+2];
`ifdef MISALIGN_CHECK_EN
   assign mis = |req_pc[1:0];
`else
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^req_pc[1:0];
   assign mis = 1'b0;
`endif
   assign req_err = mis ? 2'd2 : oor ? 2'd1 : 2'd0;

   assign occ = cnt_q + {1'b0, if_vld_q};
   assign req_ready = (occ < 2'd2) && !flush && rst_n;
   assign accept = req_valid && req_ready;

   // The in-flight read is presented directly as the head when the FIFO is empty,
   // giving one-cycle latency; otherwise it is parked in the FIFO the next edge.
   assign if_instr = (if_err_q != 2'd0) ? NOP_INSTR : rdata_q;
   assign fifo_head = cnt_q != 2'd0;
   assign pop_ff = fifo_head && rsp_ready;
   assign pop_if = if_vld_q && !fifo_head && rsp_ready;
   assign push = if_vld_q && !pop_if && !flush;

   assign rsp_valid = fifo_head || if_vld_q;
   assign rsp_instr = !rsp_valid ? '0 : fifo_head ? fifo_instr_q[rptr_q] : if_instr;
   assign rsp_pc = !rsp_valid ? '0 : fifo_head ? fifo_pc_q[rptr_q] : if_pc_q;
   assign rsp_err = !rsp_valid ? 2'd0 : fifo_head ? fifo_err_q[rptr_q] : if_err_q;

   always_comb begin
      if_vld_d = accept;
      if_pc_d = accept ? req_pc : if_pc_q;
      if_err_d = accept ? req_err : if_err_q;
      wptr_d = flush ? 1'b0 : wptr_q ^ push;
      rptr_d = flush ? 1'b0 : rptr_q ^ pop_ff;
      cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop_ff};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if_vld_q <= 1'b0;
         if_pc_q <= '0;
         if_err_q <= 2'd0;
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if_vld_q <= if_vld_d;
         if_pc_q <= if_pc_d;
         if_err_q <= if_err_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Nonblocking write and read of the same word yields the old data (read-first).
   always_ff @(posedge clk) begin
      if (ld_we) mem_q[ld_addr] <= ld_data;
      if (accept) rdata_q <= mem_q[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wptr_q] <= if_instr;
         fifo_pc_q[wptr_q] <= if_pc_q;
         fifo_err_q[wptr_q] <= if_err_q;
      end
   end
endmodule
